// File: rtl/axi_logpwr_avg_pkg.sv
// Shared constants for the axi_logpwr_avg slice.
//   INT_W        : integer bits of the log2 result (leading-one position 0..63)
//   PIPE_LAT     : registered stages from accepted sample to FIFO write
//   AFULL_MARGIN : free FIFO entries that must remain for i_tready to stay high
//   acc_width()  : accumulator width that holds 2^MAX_AVG_LOG2 worst-case powers
package axi_logpwr_avg_pkg;

  localparam int unsigned INT_W        = 6;
  localparam int unsigned PIPE_LAT     = 6;
  localparam int unsigned AFULL_MARGIN = PIPE_LAT + 1;

  function automatic int unsigned acc_width(input int unsigned in_w,
                                            input int unsigned max_avg_log2);
    return 2 * in_w + 1 + max_avg_log2;
  endfunction

endpackage

// File: rtl/axi_logpwr_avg_if.sv
// AXI-stream style handshake bundle for axi_logpwr_avg.
//   i_tdata/i_tlast/i_tvalid/i_tready : complex sample input {re, im}
//   o_tdata/o_tlast/o_tvalid/o_tready : log2 power output
// slave is the DUT view, master the view of whatever drives and drains it.
interface axi_logpwr_avg_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16
);
  logic [2*IN_W-1:0] i_tdata;
  logic              i_tlast;
  logic              i_tvalid;
  logic              i_tready;
  logic [OUT_W-1:0]  o_tdata;
  logic              o_tlast;
  logic              o_tvalid;
  logic              o_tready;

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/axi_logpwr_avg_log2_approx.sv
// Piecewise-linear log2 of an unsigned accumulator, two register stages.
//   in_valid/in_acc   : value to convert
//   out_valid/out_raw : {leading-one position, FRAC_W bits below it}
// A zero input yields zero.
module logpwr_log2_approx
  import axi_logpwr_avg_pkg::*;
#(
  parameter int unsigned ACC_W  = 41,
  parameter int unsigned FRAC_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [ACC_W-1:0]        in_acc,
  output logic                    out_valid,
  output logic [INT_W+FRAC_W-1:0] out_raw
);
  logic [INT_W-1:0]        lead_c, s4_p, shamt;
  logic [ACC_W-1:0]        s4_acc;
  logic                    s4_valid;
  logic [ACC_W+FRAC_W-1:0] norm_c;

  always_comb begin
    lead_c = '0;
    for (int unsigned i = 0; i < ACC_W; i++)
      if (in_acc[i]) lead_c = INT_W'(i);
  end

  // Move the leading one to the MSB; the appended zeros give right padding
  // when fewer than FRAC_W bits sit below it.
  assign shamt  = INT_W'(ACC_W - 1) - s4_p;
  assign norm_c = {s4_acc, {FRAC_W{1'b0}}} << shamt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s4_valid  <= 1'b0;
      s4_p      <= '0;
      s4_acc    <= '0;
      out_valid <= 1'b0;
      out_raw   <= '0;
    end else begin
      s4_valid  <= in_valid;
      s4_p      <= lead_c;
      s4_acc    <= in_acc;
      out_valid <= s4_valid;
      out_raw   <= {s4_p, norm_c[ACC_W+FRAC_W-2 -: FRAC_W]};
    end
  end
endmodule

// File: rtl/fifo_srl.sv
// Shift-register FIFO, first-word-fall-through.
//   wr_en/wr_data : push (ignored when full unless a pop happens the same cycle)
//   rd_en         : pop when rd_valid
//   rd_data       : head entry, forced to zero while empty
//   rd_valid      : FIFO not empty
//   count         : current occupancy 0..2^LOG2_DEPTH
module fifo_srl #(
  parameter int unsigned WIDTH      = 17,
  parameter int unsigned LOG2_DEPTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic [LOG2_DEPTH:0]   count
);
  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  push, pop;
  logic [LOG2_DEPTH-1:0] head;

  assign rd_valid = (count != '0);
  assign pop      = rd_en && rd_valid;
  assign push     = wr_en && ((count != (LOG2_DEPTH+1)'(DEPTH)) || pop);
  // Newest entry sits at mem[0]; the oldest is at count-1.
  assign head     = LOG2_DEPTH'(count - 1'b1);
  assign rd_data  = rd_valid ? mem[head] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[0] <= wr_data;
      for (int unsigned i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/axi_logpwr_avg.sv
// Log-power averager: re^2+im^2 accumulated over 2^N samples (or until tlast),
// converted to unsigned fixed-point log2 and divided by 2^N in the log domain.
//   clk, reset    : clock, asynchronous active-high reset
//   cfg_avg_log2  : averaging exponent N, clamped to MAX_AVG_LOG2
//   s             : input/output stream handshakes (slave view)
module axi_logpwr_avg
  import axi_logpwr_avg_pkg::*;
#(
  parameter int unsigned IN_W         = 16,
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned MAX_AVG_LOG2 = 8,
  parameter int unsigned LOG2_DEPTH   = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [$clog2(MAX_AVG_LOG2+1)-1:0] cfg_avg_log2,
  axi_logpwr_avg_if.slave                   s
);
  localparam int unsigned FRAC_W = OUT_W - INT_W;
  localparam int unsigned ACC_W  = acc_width(IN_W, MAX_AVG_LOG2);
  localparam int unsigned PWR_W  = 2 * IN_W + 1;
  localparam int unsigned N_W    = $clog2(MAX_AVG_LOG2 + 1);
  localparam int unsigned CNT_W  = MAX_AVG_LOG2 + 1;
  localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;

  logic                     accept;
  logic signed [2*IN_W-1:0] re_x, im_x;
  logic [N_W-1:0]           n_in;

  assign accept = s.i_tvalid && s.i_tready;
  assign re_x   = (2*IN_W)'($signed(s.i_tdata[2*IN_W-1 -: IN_W]));
  assign im_x   = (2*IN_W)'($signed(s.i_tdata[IN_W-1:0]));
  assign n_in   = (cfg_avg_log2 > N_W'(MAX_AVG_LOG2)) ? N_W'(MAX_AVG_LOG2) : cfg_avg_log2;

  // N rides along with each sample; S3 keeps the copy carried by the
  // window's first sample, which equals latching cfg at that acceptance.
  logic                s1_valid, s1_last, s2_valid, s2_last;
  logic [N_W-1:0]      s1_n, s2_n;
  logic [2*IN_W-1:0]   s1_re2, s1_im2;
  logic [PWR_W-1:0]    s2_pow;

  logic [CNT_W-1:0]    win_cnt, last_idx;
  logic [N_W-1:0]      win_n, n_eff, s3_n, s4_n, s5_n;
  logic [ACC_W-1:0]    acc, acc_next;
  logic                first, close, s3_valid, s3_last, s4_last, s5_last;

  logic                raw_valid;
  logic [OUT_W-1:0]    raw;
  logic [OUT_W:0]      diff_c;
  logic                s6_valid, s6_last;
  logic [OUT_W-1:0]    s6_data;

  logic [OUT_W:0]      fifo_dout;
  logic [LOG2_DEPTH:0] fifo_count;

  always_comb begin
    first    = (win_cnt == '0);
    n_eff    = first ? s2_n : win_n;
    last_idx = (CNT_W'(1) << n_eff) - 1'b1;
    acc_next = (first ? '0 : acc) + ACC_W'(s2_pow);
    close    = s2_valid && (s2_last || (win_cnt == last_idx));
  end

  assign diff_c = {1'b0, raw} - ((OUT_W+1)'(s5_n) << FRAC_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s.i_tready <= 1'b0;
      s1_valid <= 1'b0; s1_last <= 1'b0; s1_n <= '0; s1_re2 <= '0; s1_im2 <= '0;
      s2_valid <= 1'b0; s2_last <= 1'b0; s2_n <= '0; s2_pow <= '0;
      win_cnt  <= '0;   win_n   <= '0;   acc  <= '0;
      s3_valid <= 1'b0; s3_last <= 1'b0; s3_n <= '0;
      s4_last  <= 1'b0; s4_n    <= '0;   s5_last <= 1'b0; s5_n <= '0;
      s6_valid <= 1'b0; s6_last <= 1'b0; s6_data <= '0;
    end else begin
      s.i_tready <= ((LOG2_DEPTH+1)'(DEPTH) - fifo_count) > (LOG2_DEPTH+1)'(AFULL_MARGIN);
      // S1
      s1_valid <= accept;
      s1_last  <= s.i_tlast;
      s1_n     <= n_in;
      s1_re2   <= re_x * re_x;
      s1_im2   <= im_x * im_x;
      // S2
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_n     <= s1_n;
      s2_pow   <= {1'b0, s1_re2} + {1'b0, s1_im2};
      // S3: acc is the S3 data register; s3_valid marks a closed window
      s3_valid <= close;
      if (s2_valid) begin
        acc     <= acc_next;
        win_n   <= n_eff;
        win_cnt <= close ? '0 : win_cnt + 1'b1;
        s3_last <= s2_last;
        s3_n    <= n_eff;
      end
      // S4/S5 sideband alongside the log2 sub-module
      s4_last <= s3_last; s4_n <= s3_n;
      s5_last <= s4_last; s5_n <= s4_n;
      // S6
      s6_valid <= raw_valid;
      s6_last  <= s5_last;
      s6_data  <= diff_c[OUT_W] ? '0 : diff_c[OUT_W-1:0];
    end
  end

  logpwr_log2_approx #(
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W)
  ) u_log2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s3_valid),
    .in_acc    (acc),
    .out_valid (raw_valid),
    .out_raw   (raw)
  );

  fifo_srl #(
    .WIDTH      (OUT_W + 1),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (s6_valid),
    .wr_data  ({s6_last, s6_data}),
    .rd_en    (s.o_tready),
    .rd_data  (fifo_dout),
    .rd_valid (s.o_tvalid),
    .count    (fifo_count)
  );

  assign s.o_tlast = fifo_dout[OUT_W];
  assign s.o_tdata = fifo_dout[OUT_W-1:0];
endmodule

// File: tb/tb_axi_logpwr_avg.sv
module tb_axi_logpwr_avg;
  localparam int FRAC_W = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cfg_avg_log2 = '0;

  axi_logpwr_avg_if #(.IN_W(16), .OUT_W(16)) bus ();

  axi_logpwr_avg #(
    .IN_W(16), .OUT_W(16), .MAX_AVG_LOG2(8), .LOG2_DEPTH(6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_avg_log2 (cfg_avg_log2),
    .s            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               last;
    logic [3:0]         cfg;
  } stim_t;

  stim_t       stim_q[$];
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int tests = 0;
  int fails = 0;
  int m_cnt = 0;
  int m_n = 0;
  longint unsigned m_acc = 0;
  bit timeout;
  bit saw_stall;
  int stall_accepts;

  // Reference log2: leading-one position, next FRAC_W bits, minus N, floor 0.
  function automatic logic [15:0] ref_log2(input longint unsigned a, input int n);
    int p = -1;
    longint unsigned frac;
    int raw;
    for (int i = 0; i < 64; i++) if (a[i]) p = i;
    if (p < 0) return 16'h0000;
    if (p >= FRAC_W) frac = (a >> (p - FRAC_W)) & 64'h3FF;
    else             frac = (a << (FRAC_W - p)) & 64'h3FF;
    raw = p * 1024 + int'(frac) - n * 1024;
    if (raw < 0) raw = 0;
    return 16'(raw);
  endfunction

  task automatic model_accept(input stim_t st);
    longint r = st.re;
    longint q = st.im;
    if (m_cnt == 0) begin
      m_n   = (st.cfg > 8) ? 8 : int'(st.cfg);
      m_acc = 0;
    end
    m_acc += longint'(r * r + q * q);
    m_cnt++;
    if (st.last || m_cnt == (1 << m_n)) begin
      exp_q.push_back({st.last, ref_log2(m_acc, m_n)});
      m_cnt = 0;
    end
  endtask

  task automatic add(input int re, input int im, input bit last, input int cfg);
    stim_t st;
    st.re = 16'(re); st.im = 16'(im); st.last = last; st.cfg = 4'(cfg);
    stim_q.push_back(st);
  endtask

  task automatic clear_q();
    stim_q.delete(); exp_q.delete(); got_q.delete();
  endtask

  // Drives stim_q, feeds the model on every handshake and collects outputs.
  // rmode: 0 ready, 1 random ready, 2 not ready for first 200 cycles, 3 never ready.
  task automatic run(input int rmode, input bit drain);
    int cyc = 0;
    int idx = 0;
    int n = stim_q.size();
    timeout = 0; saw_stall = 0; stall_accepts = 0;
    forever begin
      @(negedge clk);
      case (rmode)
        0:       bus.o_tready = 1'b1;
        1:       bus.o_tready = ($urandom_range(0, 3) != 0);
        2:       bus.o_tready = (cyc >= 200);
        default: bus.o_tready = 1'b0;
      endcase
      if (idx < n) begin
        bus.i_tdata  = {stim_q[idx].re, stim_q[idx].im};
        bus.i_tlast  = stim_q[idx].last;
        cfg_avg_log2 = stim_q[idx].cfg;
        bus.i_tvalid = 1'b1;
        if (!bus.i_tready) saw_stall = 1;
      end else begin
        bus.i_tvalid = 1'b0;
      end
      if (bus.i_tvalid && bus.i_tready) begin
        model_accept(stim_q[idx]);
        idx++;
        if (cyc < 200) stall_accepts++;
      end
      if (bus.o_tvalid && bus.o_tready) got_q.push_back({bus.o_tlast, bus.o_tdata});
      cyc++;
      if (idx == n && (!drain || got_q.size() == exp_q.size())) break;
      if (cyc > 4 * n + 1000) begin timeout = 1; break; end
    end
    @(posedge clk); #1;
    bus.i_tvalid = 1'b0; bus.i_tlast = 1'b0; bus.o_tready = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_tvalid = 1'b0; bus.i_tlast = 1'b0; bus.i_tdata = '0; bus.o_tready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus.i_tready !== 1'b0) begin fails++; $display("FAIL rst_i_tready got %b exp 0", bus.i_tready); end
    tests++; if (bus.o_tvalid !== 1'b0) begin fails++; $display("FAIL rst_o_tvalid got %b exp 0", bus.o_tvalid); end
    tests++; if (bus.o_tdata !== 16'h0) begin fails++; $display("FAIL rst_o_tdata got %h exp 0000", bus.o_tdata); end
    tests++; if (bus.o_tlast !== 1'b0) begin fails++; $display("FAIL rst_o_tlast got %b exp 0", bus.o_tlast); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (bus.i_tready !== 1'b1) begin fails++; $display("FAIL first_ready got %b exp 1", bus.i_tready); end
  endtask

  task automatic test_latency();
    int lat = 0;
    @(negedge clk);
    cfg_avg_log2 = 4'd0; bus.o_tready = 1'b1; bus.i_tlast = 1'b0;
    bus.i_tdata = {16'sd16384, 16'sd0}; bus.i_tvalid = 1'b1;
    @(posedge clk); #1;
    bus.i_tvalid = 1'b0;
    while (!bus.o_tvalid && lat < 20) begin @(negedge clk); lat++; end
    tests++; if (lat != 7) begin fails++; $display("FAIL latency got %0d exp 7", lat); end
    tests++; if (bus.o_tdata !== 16'h7000) begin fails++; $display("FAIL lat_data got %h exp 7000", bus.o_tdata); end
    tests++; if (bus.o_tlast !== 1'b0) begin fails++; $display("FAIL lat_last got %b exp 0", bus.o_tlast); end
    repeat (2) @(negedge clk);
    tests++; if (bus.o_tvalid !== 1'b0) begin fails++; $display("FAIL lat_pop got %b exp 0", bus.o_tvalid); end
    bus.o_tready = 1'b0;
  endtask

  task automatic test_n0_values();
    logic [16:0] want [4];
    want[0] = {1'b0, 16'h7400}; want[1] = {1'b0, 16'h7800};
    want[2] = {1'b0, 16'h0000}; want[3] = {1'b1, 16'h7C00};
    clear_q();
    add(16384, 16384, 0, 0); add(-32768, 0, 0, 0); add(0, 0, 0, 0); add(-32768, -32768, 1, 0);
    run(0, 1);
    tests++; if (timeout || got_q.size() != 4) begin fails++; $display("FAIL n0_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== want[i]) begin fails++; $display("FAIL n0_val[%0d] got %h exp %h", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_avg4();
    int bad = 0;
    clear_q();
    for (int i = 0; i < 400; i++) add(16384, 0, 0, 2);
    run(0, 1);
    tests++; if (timeout || got_q.size() != 100) begin fails++; $display("FAIL avg4_count got %0d exp 100", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== {1'b0, 16'h7000}) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL avg4_val got %0d wrong exp 0 wrong", bad); end
    repeat (12) @(negedge clk);
    tests++; if (bus.o_tvalid !== 1'b0) begin fails++; $display("FAIL avg4_extra got %b exp 0", bus.o_tvalid); end
  endtask

  task automatic test_tlast();
    clear_q();
    add(16384, 0, 0, 2); add(16384, 0, 1, 2);
    for (int i = 0; i < 4; i++) add(16384, 0, 0, 2);
    run(0, 1);
    tests++; if (timeout || got_q.size() != 2) begin fails++; $display("FAIL tlast_count got %0d exp 2", got_q.size()); end
    if (got_q.size() == 2) begin
      tests++; if (got_q[0] !== {1'b1, 16'h6C00}) begin fails++; $display("FAIL tlast_early got %h exp 16c00", got_q[0]); end
      tests++; if (got_q[1] !== {1'b0, 16'h7000}) begin fails++; $display("FAIL tlast_next got %h exp 07000", got_q[1]); end
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_q();
    for (int i = 0; i < 300; i++) add(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 0, 0);
    run(2, 1);
    tests++; if (timeout) begin fails++; $display("FAIL bp_timeout got 1 exp 0"); end
    tests++; if (!saw_stall) begin fails++; $display("FAIL bp_ready_drop got 0 exp 1"); end
    tests++; if (stall_accepts > 64) begin fails++; $display("FAIL bp_stall_accepts got %0d exp <=64", stall_accepts); end
    tests++; if (got_q.size() != 300) begin fails++; $display("FAIL bp_count got %0d exp 300", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_order got %0d wrong exp 0 wrong", bad); end
  endtask

  task automatic test_random();
    int bad = 0;
    int cfg = 0;
    clear_q();
    for (int i = 0; i < 10000; i++) begin
      if (i % 37 == 0) cfg = int'($urandom_range(0, 9));
      add(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
          ($urandom_range(0, 15) == 0), cfg);
    end
    run(1, 1);
    tests++; if (timeout || got_q.size() != exp_q.size()) begin fails++; $display("FAIL rnd_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        if (bad <= 5) $display("FAIL rnd_val[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rnd_total got %0d wrong exp 0 wrong", bad); end
  endtask

  task automatic test_reset_midwindow();
    clear_q();
    add(1000, 0, 1, 0);
    for (int i = 0; i < 29; i++) add(16384, 0, 0, 0);
    add(16384, 0, 0, 2); add(16384, 0, 0, 2);
    run(3, 0);
    repeat (10) @(negedge clk);
    tests++; if (bus.o_tvalid !== 1'b1) begin fails++; $display("FAIL mid_prefill got %b exp 1", bus.o_tvalid); end
    #2 reset = 1'b1;
    #1;
    tests++; if (bus.o_tvalid !== 1'b0) begin fails++; $display("FAIL mid_o_tvalid got %b exp 0", bus.o_tvalid); end
    tests++; if (bus.o_tdata !== 16'h0) begin fails++; $display("FAIL mid_o_tdata got %h exp 0000", bus.o_tdata); end
    tests++; if (bus.i_tready !== 1'b0) begin fails++; $display("FAIL mid_i_tready got %b exp 0", bus.i_tready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_cnt = 0;
    clear_q();
    for (int i = 0; i < 4; i++) add(16384, 0, 0, 2);
    run(0, 1);
    tests++; if (timeout || got_q.size() != 1) begin fails++; $display("FAIL mid_post_count got %0d exp 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      tests++; if (got_q[0] !== {1'b0, 16'h7000}) begin fails++; $display("FAIL mid_post_val got %h exp 07000", got_q[0]); end
    end
    repeat (12) @(negedge clk);
    tests++; if (bus.o_tvalid !== 1'b0) begin fails++; $display("FAIL mid_post_extra got %b exp 0", bus.o_tvalid); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_n0_values();
    test_avg4();
    test_tlast();
    test_backpressure();
    test_random();
    test_reset_midwindow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
